syn_pipl_elastic: RTL and testbench

- Parametrised elastic pipeline register with valid/ready handshake. It replaces the enable/nop-only pipeline interface between core stages.
- Carries a BITS-wide payload plus an is-nop tag through STAGES chained two-entry skid stages, so back-pressure never forms a combinational ready path longer than one stage.
- Synchronous flush drops all in-flight entries; nop tag passes through unmodified.

---
 rtl/syn_pipl_elastic_pkg.sv | 25 ++
 rtl/syn_pipl_skid_stage.sv | 90 +++++++++
 rtl/syn_pipl_elastic.sv | 88 ++++++++
 tb/tb_syn_pipl_elastic.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/syn_pipl_elastic_pkg.sv
// ============================================================================
// Module   : syn_pipl_elastic_pkg
// Purpose  : Shared stage-state encoding, perf counter width and helpers
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package syn_pipl_elastic_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

  localparam int PERF_W = 32;

  // Saturating increment: the counter sticks at all-ones instead of wrapping
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/syn_pipl_skid_stage.sv
// ============================================================================
// Module   : syn_pipl_skid_stage
// Purpose  : Two-entry skid stage (main + skid register) with synchronous flush
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module syn_pipl_skid_stage
  import syn_pipl_elastic_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_nop,
  input  logic [BITS-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_nop,
  output logic [BITS-1:0] out_data
);

  localparam int c_W = BITS + 1;

  stage_state_t   r_state;
  logic [c_W-1:0] r_main;
  logic [c_W-1:0] r_skid;
  logic           w_accept;
  logic           w_fire;

  // Ready depends only on local state, which keeps the ready chain one stage long
  assign in_ready  = (r_state != FULL) && !flush;
  assign out_valid = (r_state != EMPTY);
  assign w_accept  = in_valid && in_ready;
  assign w_fire    = out_valid && out_ready;
  assign {out_nop, out_data} = r_main;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else if (flush) begin
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            r_state <= ONE;
            r_main  <= {in_nop, in_data};
          end
        end
        ONE: begin
          case ({w_accept, w_fire})
            2'b11: r_main <= {in_nop, in_data};
            2'b10: begin
              r_state <= FULL;
              r_skid  <= {in_nop, in_data};
            end
            2'b01: begin
              r_state <= EMPTY;
              r_main  <= '0;
            end
            default: ;
          endcase
        end
        FULL: begin
          if (w_fire) begin
            r_state <= ONE;
            r_main  <= r_skid;
            r_skid  <= '0;
          end
        end
        default: begin
          r_state <= EMPTY;
          r_main  <= '0;
          r_skid  <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/syn_pipl_elastic.sv
// ============================================================================
// Module   : syn_pipl_elastic
// Purpose  : Elastic valid/ready pipeline of STAGES chained skid stages.
//            Optional perf counters enabled by macro SYN_PIPL_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module syn_pipl_elastic
  import syn_pipl_elastic_pkg::*;
#(
  parameter int BITS   = 32,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_nop,
  input  logic [BITS-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_nop,
  output logic [BITS-1:0]   out_data
`ifdef SYN_PIPL_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_flush_cnt
`endif
);

  // Link k sits between stage k-1 and stage k; link 0 is the block input
  logic [STAGES:0] w_valid;
  logic [STAGES:0] w_ready;
  logic [STAGES:0] w_nop;
  logic [BITS-1:0] w_data [STAGES+1];

  assign w_valid[0]      = in_valid;
  assign w_nop[0]        = in_nop;
  assign w_data[0]       = in_data;
  assign in_ready        = w_ready[0];
  assign w_ready[STAGES] = out_ready;
  assign out_valid       = w_valid[STAGES];
  assign out_nop         = w_nop[STAGES];
  assign out_data        = w_data[STAGES];

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      syn_pipl_skid_stage #(
        .BITS (BITS)
      ) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (w_valid[gi]),
        .in_ready  (w_ready[gi]),
        .in_nop    (w_nop[gi]),
        .in_data   (w_data[gi]),
        .out_valid (w_valid[gi+1]),
        .out_ready (w_ready[gi+1]),
        .out_nop   (w_nop[gi+1]),
        .out_data  (w_data[gi+1])
      );
    end
  endgenerate

`ifdef SYN_PIPL_PERF_EN
  // A stage holding anything always has its main register valid
  logic w_any_busy;
  assign w_any_busy = |w_valid[STAGES:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (in_valid && !in_ready && !flush)
        perf_stall_cnt <= sat_inc(perf_stall_cnt);
      if (flush && w_any_busy)
        perf_flush_cnt <= sat_inc(perf_flush_cnt);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_syn_pipl_elastic.sv
// ============================================================================
// Module   : tb_syn_pipl_elastic
// Purpose  : Self-checking bench for syn_pipl_elastic (STAGES=2 and STAGES=1)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_syn_pipl_elastic;

  localparam int BITS = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_nop = 1'b0;
  logic [BITS-1:0] in_data = '0;
  logic            out_ready = 1'b0;

  logic [1:0]      ir;
  logic [1:0]      ov;
  logic [1:0]      onop;
  logic [BITS-1:0] od [2];
`ifdef SYN_PIPL_PERF_EN
  logic [31:0]     psc [2];
  logic [31:0]     pfc [2];
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: each stage is a 2-deep FIFO whose head drives that stage's output
  int            ns [2];
  logic [BITS:0] ent [2][2][2];
  int            n [2][2];
  int            m_stall [2];
  int            m_flush [2];

  always #5 clk = ~clk;

  syn_pipl_elastic #(.BITS(BITS), .STAGES(2)) u_dut2 (
    .clk (clk), .rst_n (rst_n), .flush (flush),
    .in_valid (in_valid), .in_ready (ir[0]), .in_nop (in_nop), .in_data (in_data),
    .out_valid (ov[0]), .out_ready (out_ready), .out_nop (onop[0]), .out_data (od[0])
`ifdef SYN_PIPL_PERF_EN
    , .perf_stall_cnt (psc[0]), .perf_flush_cnt (pfc[0])
`endif
  );

  syn_pipl_elastic #(.BITS(BITS), .STAGES(1)) u_dut1 (
    .clk (clk), .rst_n (rst_n), .flush (flush),
    .in_valid (in_valid), .in_ready (ir[1]), .in_nop (in_nop), .in_data (in_data),
    .out_valid (ov[1]), .out_ready (out_ready), .out_nop (onop[1]), .out_data (od[1])
`ifdef SYN_PIPL_PERF_EN
    , .perf_stall_cnt (psc[1]), .perf_flush_cnt (pfc[1])
`endif
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_clear(bit perf_too);
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < 2; s++) begin
        n[d][s] = 0;
        ent[d][s][0] = '0;
        ent[d][s][1] = '0;
      end
      if (perf_too) begin
        m_stall[d] = 0;
        m_flush[d] = 0;
      end
    end
  endfunction

  function automatic void model_step();
    for (int d = 0; d < 2; d++) begin
      int S;
      bit fire [2];
      bit acc0;
      logic [BITS:0] item;
      S = ns[d];
      if (flush) begin
        if (n[d][0] > 0 || n[d][1] > 0) m_flush[d]++;
        for (int s = 0; s < 2; s++) n[d][s] = 0;
      end else begin
        if (in_valid && n[d][0] == 2) m_stall[d]++;
        for (int s = 0; s < S; s++) begin
          if (s == S - 1) fire[s] = (n[d][s] > 0) && out_ready;
          else            fire[s] = (n[d][s] > 0) && (n[d][s+1] < 2);
        end
        acc0 = in_valid && (n[d][0] < 2);
        for (int s = S - 1; s >= 0; s--) begin
          if (fire[s]) begin
            item = ent[d][s][0];
            ent[d][s][0] = ent[d][s][1];
            ent[d][s][1] = '0;
            n[d][s]--;
            if (s < S - 1) begin
              ent[d][s+1][n[d][s+1]] = item;
              n[d][s+1]++;
            end
          end
        end
        if (acc0) begin
          ent[d][0][n[d][0]] = {in_nop, in_data};
          n[d][0]++;
        end
      end
    end
  endfunction

  function automatic void compare_dut(int d);
    int S;
    logic exp_v;
    logic [BITS:0] exp_p;
    S = ns[d];
    exp_v = (n[d][S-1] > 0);
    exp_p = exp_v ? ent[d][S-1][0] : '0;
    chk($sformatf("d%0d out_valid", d), {31'd0, ov[d]}, {31'd0, exp_v});
    chk($sformatf("d%0d out_payload", d), {23'd0, onop[d], od[d]}, {23'd0, exp_p});
    chk($sformatf("d%0d in_ready", d), {31'd0, ir[d]}, {31'd0, (n[d][0] < 2) && !flush});
`ifdef SYN_PIPL_PERF_EN
    chk($sformatf("d%0d perf_stall", d), psc[d], m_stall[d]);
    chk($sformatf("d%0d perf_flush", d), pfc[d], m_flush[d]);
`endif
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      compare_dut(0);
      compare_dut(1);
    end
  end

  task automatic drive(input logic v, input logic nop, input logic [BITS-1:0] data,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_nop    = nop;
    in_data   = data;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cyc(input logic v, input logic nop, input logic [BITS-1:0] data,
                     input logic ordy, input logic fl);
    drive(v, nop, data, ordy, fl);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef SYN_PIPL_PERF_EN
    int base_s;
    int base_f;
`endif
    ns[0] = 2;
    ns[1] = 1;
    model_clear(1'b1);
    drive(0, 0, '0, 0, 0);
    #12;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    chk("reset out_valid", {30'd0, ov}, 32'd0);
    chk("reset in_ready", {30'd0, ir}, 32'd3);
    chk("reset out_data", {24'd0, od[0]}, 32'd0);

    // Unstalled stream 0x1..0x8: STAGES=2 shows value k-1 after edge k
    for (int k = 1; k <= 8; k++) begin
      cyc(1, 0, BITS'(k), 1, 0);
      if (k == 1) chk("stream s2 first edge empty", {31'd0, ov[0]}, 32'd0);
      else        chk("stream s2 data", {24'd0, od[0]}, k - 1);
      chk("stream s1 data", {24'd0, od[1]}, k);
      chk("stream in_ready", {30'd0, ir}, 32'd3);
    end
    for (int k = 0; k < 3; k++) cyc(0, 0, '0, 1, 0);

    // Back-pressure on STAGES=1: A,B fill it, C waits upstream
    cyc(1, 0, 8'h0A, 0, 0);
    cyc(1, 0, 8'h0B, 0, 0);
    chk("s1 full in_ready", {31'd0, ir[1]}, 32'd0);
    cyc(1, 0, 8'h0C, 0, 0);
    chk("s1 held head", {24'd0, od[1]}, 32'h0A);
    cyc(1, 0, 8'h0C, 1, 0);
    chk("s1 drain 2nd", {24'd0, od[1]}, 32'h0B);
    cyc(1, 0, 8'h0C, 1, 0);
    chk("s1 drain 3rd", {24'd0, od[1]}, 32'h0C);
    cyc(0, 0, '0, 1, 0);
    chk("s1 drained", {31'd0, ov[1]}, 32'd0);
    for (int k = 0; k < 6; k++) cyc(0, 0, '0, 1, 0);

    // Flush of a FULL stage while offering 0xD
    cyc(1, 0, 8'h01, 0, 0);
    cyc(1, 0, 8'h02, 0, 0);
    drive(1, 0, 8'h0D, 0, 1);
    #1;
    chk("flush in_ready low", {30'd0, ir}, 32'd0);
    tick();
    drive(0, 0, '0, 1, 0);
    #1;
    chk("post-flush out_valid", {30'd0, ov}, 32'd0);
    chk("post-flush out_data", {24'd0, od[1]}, 32'd0);
    chk("post-flush in_ready", {30'd0, ir}, 32'd3);
    tick();
    chk("0xD not captured", {30'd0, ov}, 32'd0);

    // nop tag rides through untouched
    cyc(1, 1, 8'h55, 1, 0);
    chk("nop s1", {23'd0, ov[1], onop[1], od[1]}, 32'h355);
    cyc(0, 0, '0, 1, 0);
    chk("nop s2", {23'd0, ov[0], onop[0], od[0]}, 32'h355);
    for (int k = 0; k < 3; k++) cyc(0, 0, '0, 1, 0);

    // Async reset mid-stall with three entries buffered in STAGES=2
    cyc(1, 0, 8'h21, 0, 0);
    cyc(1, 0, 8'h22, 0, 0);
    cyc(1, 0, 8'h23, 0, 0);
    drive(0, 0, '0, 0, 0);
    #2;
    rst_n = 1'b0;
    model_clear(1'b1);
    #1;
    chk("async rst out_valid", {30'd0, ov}, 32'd0);
    chk("async rst out_data", {15'd0, onop[0], od[0], onop[1], od[1]}, 32'd0);
    #3;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, '0, 1, 0);
      chk("no entries after reset", {30'd0, ov}, 32'd0);
    end

    // Five stalled cycles on STAGES=1, then a flush of the non-empty pipe
    cyc(1, 0, 8'h31, 0, 0);
    cyc(1, 0, 8'h32, 0, 0);
`ifdef SYN_PIPL_PERF_EN
    base_s = int'(psc[1]);
    base_f = int'(pfc[1]);
`endif
    for (int k = 0; k < 5; k++) cyc(1, 0, 8'h33, 0, 0);
    cyc(1, 0, 8'h33, 0, 1);
    drive(0, 0, '0, 1, 0);
    #1;
`ifdef SYN_PIPL_PERF_EN
    chk("perf stall delta", psc[1] - base_s, 32'd5);
    chk("perf flush delta", pfc[1] - base_f, 32'd1);
`endif
    chk("perf scenario flushed", {30'd0, ov}, 32'd0);
    tick();
    tick();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
